vga_collision_probe: RTL and testbench

Pixel-stream reader that sits on the `vga_if` bus downstream of the background/maze drawing stage. It inspects the rendered RGB stream once per frame in four one-pixel probe strips bordering the player box: up, down, left and right. For each direction it reports whether wall-coloured pixels are present. Game logic uses these flags to block player motion. The result is delivered once per frame through a valid/ack handshake.

---
 rtl/vga_collision_probe_if.sv | 14 +
 rtl/vga_collision_probe.sv | 171 +++++++++++++++++
 tb/tb_vga_collision_probe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_collision_probe_if.sv
// VGA pixel-stream bus: timing counters, sync/blank flags and the rgb value
// aligned with hcount/vcount on the same cycle.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_collision_probe.sv
// Counts wall-coloured pixels in four one-pixel strips around the player box once
// per frame and hands the per-direction blocked flags to game logic via valid/ack.
module vga_collision_probe #(
  parameter logic [11:0] WALL_RGB   = 12'h00f,
  parameter int unsigned BOX_SIZE   = 30,
  parameter int unsigned HIT_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        result_ack,
  output logic        result_valid,
  output logic        blocked_up,
  output logic        blocked_down,
  output logic        blocked_left,
  output logic        blocked_right,
  output logic [7:0]  cnt_up,
  output logic [7:0]  cnt_down,
  output logic [7:0]  cnt_left,
  output logic [7:0]  cnt_right,
  output logic        overrun
);

  localparam int unsigned HorPixels = 1024;
  localparam int unsigned VerPixels = 768;
  localparam logic signed [11:0] BoxS = 12'(BOX_SIZE);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  // Direction index: 0 up, 1 down, 2 left, 3 right.
  state_e          state_q, state_d;
  logic [10:0]     px_q, px_d, py_q, py_d;
  logic [3:0][7:0] acc_q, acc_d;
  logic [3:0][7:0] cnt_q, cnt_d;
  logic [3:0]      blk_q, blk_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic sample, frame_start, frame_end;
  logic scan_en, report_load;

  assign sample      = ~vga_in.hblnk & ~vga_in.vblnk;
  assign frame_start = sample && (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
  assign frame_end   = sample && (vga_in.hcount == 11'(HorPixels - 1)) &&
                       (vga_in.vcount == 11'(VerPixels - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (frame_start) state_d = StScan;
      StScan:   if (frame_start) state_d = StScan;
                else if (frame_end) state_d = StReport;
      StReport: if (frame_start) state_d = StScan;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs; the frame-start pixel belongs to the new frame in every state.
  always_comb begin
    scan_en     = (state_q == StScan) || frame_start;
    report_load = (state_q == StScan) && frame_end && !frame_start;
  end

  always_comb begin
    px_d = frame_start ? pos_x : px_q;
    py_d = frame_start ? pos_y : py_q;
  end

  // Strip membership on the position in force for this pixel.
  logic signed [11:0] hs, vs, pxs, pys;
  logic               in_cols, in_rows, is_wall;
  logic [3:0]         hit;

  always_comb begin
    hs      = $signed({1'b0, vga_in.hcount});
    vs      = $signed({1'b0, vga_in.vcount});
    pxs     = $signed({1'b0, px_d});
    pys     = $signed({1'b0, py_d});
    in_cols = (hs >= pxs) && (hs <= pxs + BoxS - 12'sd1);
    in_rows = (vs >= pys) && (vs <= pys + BoxS - 12'sd1);
    hit[0]  = (vs == pys - 12'sd1) && in_cols;
    hit[1]  = (vs == pys + BoxS) && in_cols;
    hit[2]  = (hs == pxs - 12'sd1) && in_rows;
    hit[3]  = (hs == pxs + BoxS) && in_rows;
    is_wall = sample && scan_en && (vga_in.rgb == WALL_RGB);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = frame_start ? 8'd0 : acc_q[i];
      if (is_wall && hit[i] && (acc_d[i] != 8'hff)) begin
        acc_d[i] = acc_d[i] + 8'd1;
      end
    end
  end

  // Strips that fall off the screen always block.
  logic [12:0] px_end, py_end;
  logic [3:0]  outside;

  always_comb begin
    px_end     = {2'b00, px_q} + 13'(BOX_SIZE);
    py_end     = {2'b00, py_q} + 13'(BOX_SIZE);
    outside[0] = (py_q == 11'd0);
    outside[1] = (py_end >= 13'(VerPixels));
    outside[2] = (px_q == 11'd0);
    outside[3] = (px_end >= 13'(HorPixels));
  end

  always_comb begin
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (report_load) begin
      cnt_d = acc_d;
      for (int i = 0; i < 4; i++) begin
        blk_d[i] = (32'(acc_d[i]) >= HIT_THRESH) || outside[i];
      end
      valid_d   = 1'b1;
      overrun_d = valid_q && !result_ack;
    end else if (valid_q && result_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q      <= '0;
      py_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      blk_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      px_q      <= px_d;
      py_q      <= py_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign result_valid  = valid_q;
  assign overrun       = overrun_q;
  assign cnt_up        = cnt_q[0];
  assign cnt_down      = cnt_q[1];
  assign cnt_left      = cnt_q[2];
  assign cnt_right     = cnt_q[3];
  assign blocked_up    = blk_q[0];
  assign blocked_down  = blk_q[1];
  assign blocked_left  = blk_q[2];
  assign blocked_right = blk_q[3];

endmodule

// File: tb/tb_vga_collision_probe.sv
// Drives sparse frames (frame start, box neighbourhood, frame end) and checks the
// per-frame result against a coordinate-rule model of the strips and handshake.
module tb_vga_collision_probe;

  localparam int          B    = 30;
  localparam logic [11:0] WALL = 12'h00f;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pos_x, pos_y;
  logic        result_ack;
  logic        result_valid, overrun;
  logic        blocked_up, blocked_down, blocked_left, blocked_right;
  logic [7:0]  cnt_up, cnt_down, cnt_left, cnt_right;

  vga_if vga ();

  vga_collision_probe dut (
    .clk          (clk),
    .rst          (rst),
    .vga_in       (vga),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .result_ack   (result_ack),
    .result_valid (result_valid),
    .blocked_up   (blocked_up),
    .blocked_down (blocked_down),
    .blocked_left (blocked_left),
    .blocked_right(blocked_right),
    .cnt_up       (cnt_up),
    .cnt_down     (cnt_down),
    .cnt_left     (cnt_left),
    .cnt_right    (cnt_right),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic [11:0] rgb;
  } pix_t;

  pix_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cnt[4];
  bit   m_blk[4];
  bit   m_valid, m_over;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Which strip a pixel lies in: 0 up, 1 down, 2 left, 3 right, -1 none.
  function automatic int strip_of(int h, int v, int px, int py);
    if (v == py - 1 && h >= px && h < px + B) return 0;
    if (v == py + B && h >= px && h < px + B) return 1;
    if (h == px - 1 && v >= py && v < py + B) return 2;
    if (h == px + B && v >= py && v < py + B) return 3;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vga.hcount = '0; vga.vcount = '0; vga.hblnk = 1'b1; vga.vblnk = 1'b1;
    vga.rgb = WALL; vga.hsync = 1'b0; vga.vsync = 1'b0;
    result_ack = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input int h, input int v, input logic [11:0] rgb, input bit hb);
    pix_t p;
    p.h = 11'(h); p.v = 11'(v); p.hb = hb; p.rgb = rgb;
    q.push_back(p);
  endtask

  task automatic new_frame(input logic [11:0] rgb0);
    q.delete();
    push(0, 0, rgb0, 1'b0);
  endtask

  // Every pixel of the box ring region; pct<0 means all black.
  task automatic add_hood(input int px, input int py, input int pct);
    for (int v = py - 1; v <= py + B; v++) begin
      for (int h = px - 1; h <= px + B; h++) begin
        if (h < 0 || v < 0 || h > 1023 || v > 767) continue;
        if ((h == 0 && v == 0) || (h == 1023 && v == 767)) continue;
        if (pct < 0) push(h, v, 12'h000, 1'b0);
        else push(h, v, ($urandom_range(99) < pct) ? WALL : 12'($urandom),
                  ($urandom_range(15) == 0));
      end
    end
  endtask

  task automatic add_scatter(input int n);
    for (int i = 0; i < n; i++) begin
      push($urandom_range(1022) + 1, $urandom_range(766), WALL, 1'b0);
    end
  endtask

  task automatic end_frame(input logic [11:0] rgb);
    push(1023, 767, rgb, 1'b0);
  endtask

  task automatic play(input int px, input int py, input bit ack_last, input int rst_v,
                      input string tag);
    bit rst_done;
    int s;
    rst_done = 0;
    pos_x = 11'(px);
    pos_y = 11'(py);
    for (int i = 0; i < q.size(); i++) begin
      vga.hcount = q[i].h; vga.vcount = q[i].v;
      vga.hblnk = q[i].hb; vga.vblnk = 1'b0; vga.rgb = q[i].rgb;
      rst = 1'b0;
      if (rst_v >= 0 && !rst_done && int'(q[i].v) == rst_v) begin
        rst = 1'b1;
        rst_done = 1;
      end
      result_ack = (i == q.size() - 1) ? ack_last : 1'b0;
      if (i == q.size() - 1) chk({tag, "_valid_before_end"}, result_valid,
                                 rst_done ? 1'b0 : m_valid);
      step();
      // Mid-frame position changes must not matter.
      if (i == 0) begin
        pos_x = 11'($urandom);
        pos_y = 11'($urandom);
      end
    end
    rst = 1'b0;
    result_ack = 1'b0;
    if (rst_done) begin
      m_valid = 0; m_over = 0;
      for (int d = 0; d < 4; d++) begin m_cnt[d] = 0; m_blk[d] = 0; end
    end else begin
      for (int d = 0; d < 4; d++) m_cnt[d] = 0;
      foreach (q[i]) begin
        if (!q[i].hb && q[i].rgb == WALL) begin
          s = strip_of(int'(q[i].h), int'(q[i].v), px, py);
          if (s >= 0) m_cnt[s]++;
        end
      end
      for (int d = 0; d < 4; d++) if (m_cnt[d] > 255) m_cnt[d] = 255;
      m_blk[0] = (m_cnt[0] >= 1) || (py == 0);
      m_blk[1] = (m_cnt[1] >= 1) || (py + B >= 768);
      m_blk[2] = (m_cnt[2] >= 1) || (px == 0);
      m_blk[3] = (m_cnt[3] >= 1) || (px + B >= 1024);
      m_over   = m_valid && !ack_last;
      m_valid  = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"},     result_valid,  m_valid);
    chk({tag, "_overrun"},   overrun,       m_over);
    chk({tag, "_cnt_up"},    cnt_up,        m_cnt[0]);
    chk({tag, "_cnt_down"},  cnt_down,      m_cnt[1]);
    chk({tag, "_cnt_left"},  cnt_left,      m_cnt[2]);
    chk({tag, "_cnt_right"}, cnt_right,     m_cnt[3]);
    chk({tag, "_blk_up"},    blocked_up,    m_blk[0]);
    chk({tag, "_blk_down"},  blocked_down,  m_blk[1]);
    chk({tag, "_blk_left"},  blocked_left,  m_blk[2]);
    chk({tag, "_blk_right"}, blocked_right, m_blk[3]);
  endtask

  task automatic ack_pulse(input string tag);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    if (m_valid) begin m_valid = 0; m_over = 0; end
    chk({tag, "_ack_valid"},   result_valid, m_valid);
    chk({tag, "_ack_overrun"}, overrun,      m_over);
  endtask

  int px, py;

  initial begin
    rst = 1'b1; pos_x = '0; pos_y = '0;
    m_valid = 0; m_over = 0;
    for (int d = 0; d < 4; d++) begin m_cnt[d] = 0; m_blk[d] = 0; end
    idle(3);
    rst = 1'b0;
    idle(2);
    check_all("reset");

    // All-black frame.
    new_frame(12'h000); add_hood(497, 369, -1); end_frame(12'h000);
    play(497, 369, 0, -1, "black"); check_all("black"); ack_pulse("black");
    idle(4);

    // Strip hits, a corner hit and blanked wall pixels.
    new_frame(12'h000);
    push(500, 368, WALL, 1'b0); push(527, 380, WALL, 1'b0);
    push(496, 368, WALL, 1'b0); push(500, 368, WALL, 1'b1); push(527, 381, WALL, 1'b1);
    end_frame(12'h000);
    play(497, 369, 0, -1, "strips"); check_all("strips"); ack_pulse("strips");
    idle(4);

    // Box at the top-left screen corner.
    new_frame(12'h000); add_hood(0, 0, -1); end_frame(12'h000);
    play(0, 0, 0, -1, "edge00"); check_all("edge00"); ack_pulse("edge00");
    idle(4);

    // Frame-start pixel (0,0) lies in the up strip.
    new_frame(WALL); end_frame(12'h000);
    play(0, 1, 0, -1, "startpix"); check_all("startpix"); ack_pulse("startpix");
    idle(4);

    // Last pixel (1023,767) lies in the right strip; down strip off-screen.
    new_frame(12'h000); add_hood(993, 738, 50); end_frame(WALL);
    play(993, 738, 0, -1, "endpix"); check_all("endpix"); ack_pulse("endpix");
    idle(4);

    new_frame(12'h000); add_hood(994, 739, 30); end_frame(WALL);
    play(994, 739, 0, -1, "edgebr"); check_all("edgebr"); ack_pulse("edgebr");
    idle(4);

    // Saturation: the up row repeated ten times.
    new_frame(12'h000);
    for (int r = 0; r < 10; r++) for (int c = 497; c < 497 + B; c++) push(c, 368, WALL, 1'b0);
    end_frame(12'h000);
    play(497, 369, 0, -1, "sat"); check_all("sat"); ack_pulse("sat");
    idle(4);

    for (int k = 0; k < 6; k++) begin
      px = $urandom_range(1023); py = $urandom_range(767);
      new_frame(($urandom_range(3) == 0) ? WALL : 12'h000);
      add_hood(px, py, 40); add_scatter(20); end_frame(WALL);
      play(px, py, 0, -1, $sformatf("rand%0d", k)); check_all($sformatf("rand%0d", k));
      ack_pulse($sformatf("rand%0d", k));
      idle(3);
    end

    // Overrun: two frames without ack.
    new_frame(12'h000); add_hood(300, 200, 40); end_frame(12'h000);
    play(300, 200, 0, -1, "ovrN"); check_all("ovrN");
    idle(3);
    new_frame(12'h000); add_hood(600, 400, 60); end_frame(12'h000);
    play(600, 400, 0, -1, "ovrN1"); check_all("ovrN1");
    ack_pulse("ovr");
    ack_pulse("ovr_ignored");
    check_all("ovr_hold");
    idle(3);

    // Frame end coinciding with ack.
    new_frame(12'h000); add_hood(100, 100, 40); end_frame(12'h000);
    play(100, 100, 0, -1, "same0"); check_all("same0");
    idle(3);
    new_frame(12'h000); add_hood(120, 90, 40); end_frame(12'h000);
    play(120, 90, 1, -1, "same1"); check_all("same1"); ack_pulse("same1");
    idle(3);

    // Reset mid-frame, then a complete frame.
    new_frame(12'h000); add_hood(497, 369, 50);
    push(100, 400, WALL, 1'b0); push(200, 500, WALL, 1'b0); end_frame(WALL);
    play(497, 369, 0, 400, "rstmid"); check_all("rstmid");
    idle(3);
    new_frame(12'h000); add_hood(497, 369, 50); end_frame(12'h000);
    play(497, 369, 0, -1, "afterrst"); check_all("afterrst"); ack_pulse("afterrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
